// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
// Transaction controller between the SPI bridge byte interface and the PWM
// register file. Each SPI frame is decoded as a command byte followed by a
// data byte. Writes produce a single-cycle reg_wr strobe. Reads produce a
// single-cycle reg_rd strobe. The returned register byte is parked on data_out
// so the bridge transmits it at its next byte load.
//
// Command byte: bit7 = 1 write / 0 read, bit6 = high/low byte select,
// bits[5:0] = register address.
//
// Ports
//   clk        in   system clock (same domain as the SPI bridge)
//   rst        in   synchronous active-high reset
//   cs_n       in   chip select, already synchronous; high = frame inactive
//   byte_sync  in   one-cycle pulse, a byte was received
//   data_in    in   received byte, valid with byte_sync
//   data_out   out  byte the bridge loads for transmission
//   reg_addr   out  register address
//   reg_hi     out  high/low byte select
//   reg_wr     out  one-cycle write strobe
//   reg_wdata  out  write data, valid with reg_wr
//   reg_rd     out  one-cycle read strobe
//   reg_rdata  in   read data, valid one clock after reg_rd
//
// Optional feature macro: SPI_CMD_AUTOINC_EN
//   When defined, the controller stays in the data phase after each data
//   byte and steps the address (wrapping at 2^ADDR_W), giving write and read
//   bursts that end only when cs_n goes high. When undefined, every frame
//   carries one command and one data byte. A further byte is a new command.

module spi_cmd_ctrl #(
  parameter int          ADDR_W    = 6,
  parameter logic [7:0]  RST_RDATA = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_hi,
  output logic              reg_wr,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hi_q, hi_d;
  logic              wr_cmd_q, wr_cmd_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        dout_q, dout_d;
`ifdef SPI_CMD_AUTOINC_EN
  logic              inc_pend_q, inc_pend_d;
`endif

  // Next-state logic for the whole controller. The strobes default to zero
  // every cycle, so each strobe lasts exactly one clock. rd_pend follows
  // reg_rd by one clock. The register file presents its data in that cycle,
  // so data_out captures it. A read strobe that is already on the bus is
  // always captured, even if cs_n rises. Only the frame decode is abandoned.
  // cs_n high overrides byte_sync. A byte seen while the frame is inactive
  // is dropped, and the decoder returns to expecting a command byte.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    wr_cmd_d  = wr_cmd_q;
    wdata_d   = wdata_q;
    reg_wr_d  = 1'b0;
    reg_rd_d  = 1'b0;
    rd_pend_d = reg_rd_q;
    dout_d    = dout_q;
`ifdef SPI_CMD_AUTOINC_EN
    inc_pend_d = 1'b0;
`endif

    if (rd_pend_q) begin
      dout_d = reg_rdata;
    end

`ifdef SPI_CMD_AUTOINC_EN
    // A burst write steps the address one clock after its strobe. This keeps
    // reg_addr correct while reg_wr is high.
    if (inc_pend_q && !cs_n) begin
      addr_d = addr_q + 1'b1;
    end
`endif

    if (cs_n) begin
      state_d = IDLE;
    end else if (byte_sync) begin
      case (state_q)
        IDLE: begin
          addr_d   = data_in[ADDR_W-1:0];
          hi_d     = data_in[6];
          wr_cmd_d = data_in[7];
          reg_rd_d = ~data_in[7];
          state_d  = DATA;
        end
        DATA: begin
          if (wr_cmd_q) begin
            reg_wr_d = 1'b1;
            wdata_d  = data_in;
`ifdef SPI_CMD_AUTOINC_EN
            inc_pend_d = 1'b1;
`endif
          end else begin
`ifdef SPI_CMD_AUTOINC_EN
            // A burst read moves to the next address immediately. The next
            // strobe then reads the new location.
            addr_d   = addr_q + 1'b1;
            reg_rd_d = 1'b1;
`endif
          end
`ifdef SPI_CMD_AUTOINC_EN
          state_d = DATA;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs. Reset returns every output to its idle
  // value. Reset also forces the strobes low for the reset cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hi_q      <= 1'b0;
      wr_cmd_q  <= 1'b0;
      wdata_q   <= 8'h00;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      dout_q    <= RST_RDATA;
`ifdef SPI_CMD_AUTOINC_EN
      inc_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      wr_cmd_q  <= wr_cmd_d;
      wdata_q   <= wdata_d;
      reg_wr_q  <= reg_wr_d;
      reg_rd_q  <= reg_rd_d;
      rd_pend_q <= rd_pend_d;
      dout_q    <= dout_d;
`ifdef SPI_CMD_AUTOINC_EN
      inc_pend_q <= inc_pend_d;
`endif
    end
  end

  assign data_out  = dout_q;
  assign reg_addr  = addr_q;
  assign reg_hi    = hi_q;
  assign reg_wr    = reg_wr_q;
  assign reg_wdata = wdata_q;
  assign reg_rd    = reg_rd_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl
// Bench for spi_cmd_ctrl. A small register-file model answers reg_rd one
// clock later and absorbs reg_wr. A byte-stream reference model predicts
// the strobes, address, write data and data_out for each byte sent.
// Optional feature macro: SPI_CMD_AUTOINC_EN (bench follows the DUT build).

module tb_spi_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic       cs_n;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [5:0] reg_addr;
  logic       reg_hi;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_rd;
  logic [7:0] reg_rdata;

  int checks   = 0;
  int failures = 0;

  spi_cmd_ctrl #(.ADDR_W(6), .RST_RDATA(8'h00)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(data_out), .reg_addr(reg_addr),
    .reg_hi(reg_hi), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file seen by the DUT: fill with a known pattern while memInit is
  // high, return garbage except in the cycle right after reg_rd
  logic       memInit;
  logic [7:0] tbMem [128];
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 128; i++) tbMem[i] <= 8'(i * 37 + 11);
    end else if (reg_wr) begin
      tbMem[{reg_hi, reg_addr}] <= reg_wdata;
    end
    if (reg_rd) reg_rdata <= tbMem[{reg_hi, reg_addr}];
    else        reg_rdata <= 8'($urandom);
  end

  // Reference model state: what the byte stream means, independent of timing
  logic [7:0] modelMem [128];
  logic       modelHaveCmd;
  logic       modelIsWr;
  logic       modelHi;
  logic [5:0] modelAddr;
  logic [7:0] modelDout;

  // What the DUT did in response to the most recent byte
  logic       obsWr, obsRd, obsHi;
  logic [5:0] obsAddr;
  logic [7:0] obsWdata, obsDout;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic       expWr;
    logic       expRd;
    logic [5:0] expAddr;
    logic       expHi;
    logic [7:0] expWdata;
    logic [7:0] expDout;
  } vec_t;
  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic checkIdleStrobes(input string where);
    checkOutput({where, "_no_wr"}, 8'(reg_wr), 8'h0);
    checkOutput({where, "_no_rd"}, 8'(reg_rd), 8'h0);
  endtask

  task automatic frameStart();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic frameEnd();
    @(negedge clk);
    cs_n = 1'b1;
    modelHaveCmd = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkIdleStrobes("frame_end");
    end
  endtask

  // Send one byte inside an active frame and check the response. gap is the
  // number of negedges spent after the byte, so spacing is gap+1 clocks.
  task automatic sendByte(input logic [7:0] b, input int gap);
    logic       expWr, expRd, expHi;
    logic [5:0] expAddr;
    logic [7:0] expWdata;
    expWr = 1'b0; expRd = 1'b0; expHi = 1'b0; expAddr = '0; expWdata = '0;
    if (!modelHaveCmd) begin
      modelAddr    = b[5:0];
      modelHi      = b[6];
      modelIsWr    = b[7];
      modelHaveCmd = 1'b1;
      expRd        = ~b[7];
    end else if (modelIsWr) begin
      expWr    = 1'b1;
      expWdata = b;
      expAddr  = modelAddr;
      modelMem[{modelHi, modelAddr}] = b;
`ifdef SPI_CMD_AUTOINC_EN
      modelAddr = modelAddr + 6'd1;
`else
      modelHaveCmd = 1'b0;
`endif
    end else begin
`ifdef SPI_CMD_AUTOINC_EN
      modelAddr = modelAddr + 6'd1;
      expRd     = 1'b1;
`else
      modelHaveCmd = 1'b0;
`endif
    end
    if (expRd) begin
      expAddr   = modelAddr;
      modelDout = modelMem[{modelHi, modelAddr}];
    end
    if (expRd || expWr) expHi = modelHi;

    @(negedge clk);
    byte_sync = 1'b1;
    data_in   = b;
    @(negedge clk);
    byte_sync = 1'b0;
    data_in   = 8'($urandom);
    obsWr = reg_wr; obsRd = reg_rd; obsAddr = reg_addr; obsHi = reg_hi;
    obsWdata = reg_wdata;
    checkOutput("strobe_wr", 8'(reg_wr), 8'(expWr));
    checkOutput("strobe_rd", 8'(reg_rd), 8'(expRd));
    if (expWr || expRd) begin
      checkOutput("strobe_addr", 8'(reg_addr), 8'(expAddr));
      checkOutput("strobe_hi", 8'(reg_hi), 8'(expHi));
    end
    if (expWr) checkOutput("strobe_wdata", reg_wdata, expWdata);
    for (int i = 2; i <= gap; i++) begin
      @(negedge clk);
      checkIdleStrobes("gap");
      if (i == 3) begin
        obsDout = data_out;
        checkOutput("data_out", data_out, modelDout);
      end
    end
  endtask

  // One table frame: command byte then data byte, compared to fixed values
  task automatic applyStimulus(input vec_t v);
    logic       rdSeen, rdHi, wrSeen, wrHi;
    logic [5:0] rdAddr, wrAddr;
    logic [7:0] wrData;
    frameStart();
    sendByte(v.cmd, 8);
    rdSeen = obsRd; rdAddr = obsAddr; rdHi = obsHi;
    sendByte(v.dat, 8);
    wrSeen = obsWr; wrAddr = obsAddr; wrHi = obsHi; wrData = obsWdata;
    frameEnd();
    checkOutput("tbl_wr", 8'(wrSeen), 8'(v.expWr));
    checkOutput("tbl_rd", 8'(rdSeen), 8'(v.expRd));
    if (v.expWr) begin
      checkOutput("tbl_wr_addr", 8'(wrAddr), 8'(v.expAddr));
      checkOutput("tbl_wr_hi", 8'(wrHi), 8'(v.expHi));
      checkOutput("tbl_wdata", wrData, v.expWdata);
    end
    if (v.expRd) begin
      checkOutput("tbl_rd_addr", 8'(rdAddr), 8'(v.expAddr));
      checkOutput("tbl_rd_hi", 8'(rdHi), 8'(v.expHi));
    end
    checkOutput("tbl_dout", obsDout, v.expDout);
  endtask

  task automatic checkResetValues(input string where);
    checkOutput({where, "_dout"}, data_out, 8'h00);
    checkOutput({where, "_addr"}, 8'(reg_addr), 8'h00);
    checkOutput({where, "_hi"}, 8'(reg_hi), 8'h0);
    checkOutput({where, "_wr"}, 8'(reg_wr), 8'h0);
    checkOutput({where, "_rd"}, 8'(reg_rd), 8'h0);
    checkOutput({where, "_wdata"}, reg_wdata, 8'h00);
  endtask

  // Hard stop if something wedges the run
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, table frames, directed corner cases, random frames
  initial begin
    logic [7:0] b;
    int         nBytes;
    vecs[0] = '{8'hC2, 8'hA7, 1'b1, 1'b0, 6'h02, 1'b1, 8'hA7, 8'h00};
    vecs[1] = '{8'h42, 8'h00, 1'b0, 1'b1, 6'h02, 1'b1, 8'h00, 8'hA7};
    vecs[2] = '{8'h85, 8'h3C, 1'b1, 1'b0, 6'h05, 1'b0, 8'h3C, 8'hA7};
    vecs[3] = '{8'h05, 8'h00, 1'b0, 1'b1, 6'h05, 1'b0, 8'h00, 8'h3C};
    vecs[4] = '{8'hFF, 8'hE1, 1'b1, 1'b0, 6'h3F, 1'b1, 8'hE1, 8'h3C};
    vecs[5] = '{8'h7F, 8'h00, 1'b0, 1'b1, 6'h3F, 1'b1, 8'h00, 8'hE1};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 1'b0, 6'h00, 1'b0, 8'h01, 8'hE1};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 6'h00, 1'b0, 8'h00, 8'h01};

    rst = 1'b1; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00; memInit = 1'b1;
    for (int i = 0; i < 128; i++) modelMem[i] = 8'(i * 37 + 11);
    modelHaveCmd = 1'b0; modelIsWr = 1'b0; modelHi = 1'b0;
    modelAddr = '0; modelDout = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0; memInit = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Command then abort: no write, and the next frame decodes normally
    frameStart();
    sendByte(8'h81, 8);
    frameEnd();
    frameStart();
    sendByte(8'h83, 8);
    sendByte(8'h11, 8);
    checkOutput("abort_next_wr", 8'(obsWr), 8'h1);
    checkOutput("abort_next_addr", 8'(obsAddr), 8'h03);
    checkOutput("abort_next_wdata", obsWdata, 8'h11);
    frameEnd();

    // A byte arriving while cs_n is high is dropped
    @(negedge clk);
    byte_sync = 1'b1; data_in = 8'h3F;
    @(negedge clk);
    byte_sync = 1'b0;
    checkIdleStrobes("cs_high_byte");

    // Reset in the middle of a frame
    frameStart();
    sendByte(8'h81, 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetValues("midreset");
    @(negedge clk);
    checkIdleStrobes("after_reset");
    modelHaveCmd = 1'b0; modelDout = 8'h00;
    frameEnd();
    frameStart();
    sendByte(8'h83, 8);
    sendByte(8'h22, 8);
    checkOutput("post_reset_wr", 8'(obsWr), 8'h1);
    checkOutput("post_reset_wdata", obsWdata, 8'h22);
    frameEnd();

    // Three bytes in one frame: burst write, or a fresh read command
    frameStart();
    sendByte(8'hBF, 8);
    sendByte(8'h01, 8);
    checkOutput("third_first_addr", 8'(obsAddr), 8'h3F);
    checkOutput("third_first_wdata", obsWdata, 8'h01);
    sendByte(8'h02, 8);
`ifdef SPI_CMD_AUTOINC_EN
    checkOutput("burst_wrap_wr", 8'(obsWr), 8'h1);
    checkOutput("burst_wrap_addr", 8'(obsAddr), 8'h00);
    checkOutput("burst_wrap_wdata", obsWdata, 8'h02);
`else
    checkOutput("new_cmd_rd", 8'(obsRd), 8'h1);
    checkOutput("new_cmd_addr", 8'(obsAddr), 8'h02);
`endif
    frameEnd();

    // Random frames of one to four bytes, minimum byte spacing of 8 clocks
    for (int f = 0; f < 40; f++) begin
      frameStart();
      nBytes = $urandom_range(1, 4);
      for (int k = 0; k < nBytes; k++) begin
        b = 8'($urandom);
        sendByte(b, $urandom_range(7, 10));
      end
      frameEnd();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
